// File: rtl/des_key_schedule_pkg.sv
// ---------------------------------------------------------------------------
// des_pkg
// Shared DES key-schedule definitions: PC-1 / PC-2 index tables in FIPS 46-3
// numbering (bit 1 is the MSB), the standard rotation schedule, 28-bit
// rotate helpers, the byte-parity helper and the IDLE/RUN state type.
// ---------------------------------------------------------------------------
package des_pkg;

    // Bit r-1 set: round r rotates by one place, otherwise by two.
    localparam logic [15:0] DES_SHIFT_SCHEDULE = 16'h8103;

    // PC-1: 64-bit key -> 56-bit C||D. Entry i names the FIPS key bit that
    // lands in C||D bit i+1.
    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: 56-bit C||D -> 48-bit round key.
    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [27:0] rotl28(logic [27:0] x, int unsigned n);
        return (x << n) | (x >> (28 - n));
    endfunction

    function automatic logic [27:0] rotr28(logic [27:0] x, int unsigned n);
        return (x >> n) | (x << (28 - n));
    endfunction

    // Rotation amount for the round whose schedule bit is idx (round idx+1).
    function automatic int unsigned shift_amount(logic [15:0] sched, logic [3:0] idx);
        return sched[idx] ? 1 : 2;
    endfunction

    // Total rotation over all sixteen rounds; a valid schedule wraps to 28.
    function automatic int shift_total(logic [15:0] sched);
        int total;
        total = 0;
        for (int i = 0; i < 16; i++) begin
            total += sched[i] ? 1 : 2;
        end
        return total;
    endfunction

    // FIPS key bit n sits at k[64-n]; C||D bit n sits at result[56-n].
    function automatic logic [55:0] pc1(logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55 - i] = k[64 - PC1_TABLE[i]];
        end
        return r;
    endfunction

    // DES key bytes carry odd parity; any even-parity byte is an error.
    function automatic logic key_parity_err(logic [63:0] k);
        logic err;
        err = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (^k[8*b +: 8] == 1'b0) begin
                err = 1'b1;
            end
        end
        return err;
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// ---------------------------------------------------------------------------
// des_key_schedule_if
// Groups the key-load handshake and the round-key handshake of the DES key
// schedule. The master modport is the key source / round-key consumer side,
// the slave modport is the schedule generator.
//   key side : i_key_valid, o_key_ready, i_key[63:0], i_decrypt, i_abort
//   rk side  : o_rk_valid, i_rk_ready, o_rk[47:0], o_rk_idx[3:0], o_last
//   status   : o_busy, o_parity_err
// ---------------------------------------------------------------------------
interface des_key_schedule_if;
    logic        i_key_valid;
    logic        o_key_ready;
    logic [63:0] i_key;
    logic        i_decrypt;
    logic        i_abort;
    logic        o_rk_valid;
    logic        i_rk_ready;
    logic [47:0] o_rk;
    logic [3:0]  o_rk_idx;
    logic        o_last;
    logic        o_busy;
    logic        o_parity_err;

    modport master (
        output i_key_valid, i_key, i_decrypt, i_abort, i_rk_ready,
        input  o_key_ready, o_rk_valid, o_rk, o_rk_idx, o_last, o_busy, o_parity_err
    );

    modport slave (
        input  i_key_valid, i_key, i_decrypt, i_abort, i_rk_ready,
        output o_key_ready, o_rk_valid, o_rk, o_rk_idx, o_last, o_busy, o_parity_err
    );
endinterface

// File: rtl/des_key_schedule_pc2.sv
// ---------------------------------------------------------------------------
// des_pc2
// Purely combinational PC-2 permutation: selects 48 of the 56 C||D bits to
// form a DES round key.
//   i_cd[55:0] : C||D, FIPS bit n at i_cd[56-n]
//   o_rk[47:0] : round key, FIPS bit n at o_rk[48-n]
// ---------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] i_cd,
    output logic [47:0] o_rk
);

    always_comb begin
        o_rk = '0;
        for (int i = 0; i < 48; i++) begin
            o_rk[47 - i] = i_cd[56 - PC2_TABLE[i]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// ---------------------------------------------------------------------------
// des_key_schedule
// Iterated DES key schedule: takes one 64-bit key and hands out the sixteen
// 48-bit round keys, one per handshake, in encrypt (K1..K16) or decrypt
// (K16..K1) order, using a single C||D register pair.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : key load, round-key stream and status, see des_key_schedule_if
// Parameters:
//   SHIFT_SCHEDULE : bit r-1 set = round r rotates by 1, else by 2
//   PARITY_CHECK   : 1 enables the odd-parity check on key bytes
// ---------------------------------------------------------------------------
module des_key_schedule
    import des_pkg::*;
#(
    parameter logic [15:0] SHIFT_SCHEDULE = DES_SHIFT_SCHEDULE,
    parameter int          PARITY_CHECK   = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    des_key_schedule_if.slave   bus
);

    // A schedule that does not wrap to 28 cannot restore C0||D0, which the
    // decrypt order depends on.
    if (shift_total(SHIFT_SCHEDULE) != 28) begin : g_bad_schedule
        $fatal(1, "des_key_schedule: SHIFT_SCHEDULE rotation total must be 28");
    end

    state_e      state_q, state_d;
    logic [27:0] c_half_q, c_half_d;
    logic [27:0] d_half_q, d_half_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        decrypt_q, decrypt_d;
    logic        parity_err_q, parity_err_d;
    logic [47:0] pc2_rk;

    // Next-state logic. Encrypt pre-rotates at accept so K1 appears on the
    // first RUN cycle; decrypt starts from C0||D0, which equals C16||D16
    // because the rotation total is 28, and walks backwards with right
    // rotations. Abort is tested before the handshake so it always wins.
    always_comb begin
        state_d      = state_q;
        c_half_d     = c_half_q;
        d_half_d     = d_half_q;
        cnt_d        = cnt_q;
        decrypt_d    = decrypt_q;
        parity_err_d = parity_err_q;

        case (state_q)
            IDLE: begin
                if (bus.i_key_valid) begin
                    {c_half_d, d_half_d} = pc1(bus.i_key);
                    if (!bus.i_decrypt) begin
                        c_half_d = rotl28(c_half_d, shift_amount(SHIFT_SCHEDULE, 4'd0));
                        d_half_d = rotl28(d_half_d, shift_amount(SHIFT_SCHEDULE, 4'd0));
                    end
                    decrypt_d    = bus.i_decrypt;
                    cnt_d        = 4'd0;
                    parity_err_d = (PARITY_CHECK != 0) && key_parity_err(bus.i_key);
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (bus.i_abort) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (bus.i_rk_ready) begin
                    if (cnt_q == 4'd15) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        // cnt_q = r-1: encrypt needs shift(r+1) = bit r,
                        // decrypt needs shift(17-r) = bit 16-r.
                        if (decrypt_q) begin
                            c_half_d = rotr28(c_half_q, shift_amount(SHIFT_SCHEDULE, 4'd15 - cnt_q));
                            d_half_d = rotr28(d_half_q, shift_amount(SHIFT_SCHEDULE, 4'd15 - cnt_q));
                        end else begin
                            c_half_d = rotl28(c_half_q, shift_amount(SHIFT_SCHEDULE, cnt_q + 4'd1));
                            d_half_d = rotl28(d_half_q, shift_amount(SHIFT_SCHEDULE, cnt_q + 4'd1));
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            c_half_q     <= '0;
            d_half_q     <= '0;
            cnt_q        <= '0;
            decrypt_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            c_half_q     <= c_half_d;
            d_half_q     <= d_half_d;
            cnt_q        <= cnt_d;
            decrypt_q    <= decrypt_d;
            parity_err_q <= parity_err_d;
        end
    end

    des_pc2 u_pc2 (
        .i_cd (({c_half_q, d_half_q})),
        .o_rk (pc2_rk)
    );

    // Round key is forced to zero outside RUN so stale schedule material
    // never leaks onto the datapath bus.
    assign bus.o_busy       = (state_q == RUN);
    assign bus.o_key_ready  = (state_q == IDLE);
    assign bus.o_rk_valid   = (state_q == RUN);
    assign bus.o_rk         = (state_q == RUN) ? pc2_rk : '0;
    assign bus.o_rk_idx     = cnt_q;
    assign bus.o_last       = (state_q == RUN) && (cnt_q == 4'd15);
    assign bus.o_parity_err = parity_err_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_des_key_schedule
// Self-checking bench for des_key_schedule. Expected round keys come from a
// direct FIPS-style model: C0/D0 from PC-1, Ki from the cumulative rotation
// of C0/D0, then PC-2. A second instance with parity checking disabled
// shares the same stimulus.
// ---------------------------------------------------------------------------
module tb_des_key_schedule;

    localparam int TB_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int TB_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int TB_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BAD  = 64'h123457799BBCDFF1;
    localparam logic [47:0] K1_GOOD  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_GOOD = 48'hCB3D8B0E17F5;

    typedef struct {
        logic [63:0] key;
        logic        decrypt;
        logic        exp_parity;
        logic [47:0] exp_first;
        logic [47:0] exp_last;
        bit          has_kat;
        bit          stall;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    des_key_schedule_if bus0 ();
    des_key_schedule_if bus1 ();

    des_key_schedule dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0)
    );

    des_key_schedule #(.PARITY_CHECK(0)) dut_nopar (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    assign bus1.i_key_valid = bus0.i_key_valid;
    assign bus1.i_key       = bus0.i_key;
    assign bus1.i_decrypt   = bus0.i_decrypt;
    assign bus1.i_abort     = bus0.i_abort;
    assign bus1.i_rk_ready  = bus0.i_rk_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round key `round` (1..16) straight from the FIPS definition.
    function automatic logic [47:0] modelRoundKey(input logic [63:0] key, input int round);
        logic        c0 [28];
        logic        d0 [28];
        logic        cd [56];
        logic [47:0] rk;
        int          s;
        s = 0;
        for (int i = 0; i < round; i++) s += TB_SHIFTS[i];
        for (int i = 0; i < 28; i++) begin
            c0[i] = key[64 - TB_PC1[i]];
            d0[i] = key[64 - TB_PC1[28 + i]];
        end
        for (int j = 0; j < 28; j++) begin
            cd[j]      = c0[(j + s) % 28];
            cd[28 + j] = d0[(j + s) % 28];
        end
        rk = '0;
        for (int i = 0; i < 48; i++) rk[47 - i] = cd[TB_PC2[i] - 1];
        return rk;
    endfunction

    // Key presented at position p (0..15) of a schedule.
    function automatic logic [47:0] expectedRk(input logic [63:0] key, input logic dec, input int p);
        return modelRoundKey(key, dec ? (16 - p) : (p + 1));
    endfunction

    function automatic logic modelParity(input logic [63:0] key);
        for (int b = 0; b < 8; b++) begin
            if (($countones(key[8*b +: 8]) % 2) == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRound(input string tag, input logic [47:0] exp_rk, input int p);
        checkOutput({tag, " valid"}, 64'(bus0.o_rk_valid), 64'd1);
        checkOutput({tag, " rk"}, 64'(bus0.o_rk), 64'(exp_rk));
        checkOutput({tag, " idx"}, 64'(bus0.o_rk_idx), 64'(p));
        checkOutput({tag, " last"}, 64'(bus0.o_last), (p == 15) ? 64'd1 : 64'd0);
        checkOutput({tag, " key_ready"}, 64'(bus0.o_key_ready), 64'd0);
        checkOutput({tag, " busy"}, 64'(bus0.o_busy), 64'd1);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " idle valid"}, 64'(bus0.o_rk_valid), 64'd0);
        checkOutput({tag, " idle key_ready"}, 64'(bus0.o_key_ready), 64'd1);
        checkOutput({tag, " idle busy"}, 64'(bus0.o_busy), 64'd0);
    endtask

    // Offer a key for one cycle; it must be accepted at the next edge.
    task automatic applyStimulus(input string tag, input logic [63:0] key, input logic dec);
        checkOutput({tag, " key_ready before accept"}, 64'(bus0.o_key_ready), 64'd1);
        bus0.i_key_valid = 1'b1;
        bus0.i_key       = key;
        bus0.i_decrypt   = dec;
        step();
        bus0.i_key_valid = 1'b0;
        bus0.i_key       = $urandom();
        bus0.i_decrypt   = ~dec;
    endtask

    // Full schedule with optional random stalls; every cycle in RUN is
    // compared with the model, so a stalled key must stay put.
    task automatic runSchedule(input string tag, input logic [63:0] key, input logic dec,
                               input bit stall, output logic [47:0] first_rk,
                               output logic [47:0] last_rk);
        int p;
        int cycles;
        logic rdy;
        first_rk = '0;
        last_rk  = '0;
        applyStimulus(tag, key, dec);
        p = 0;
        cycles = 0;
        while (p < 16 && cycles < 200) begin
            cycles++;
            checkRound(tag, expectedRk(key, dec, p), p);
            rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rdy && p == 0)  first_rk = bus0.o_rk;
            if (rdy && p == 15) last_rk  = bus0.o_rk;
            bus0.i_rk_ready = rdy;
            step();
            if (rdy) p++;
        end
        bus0.i_rk_ready = 1'b0;
        checkOutput({tag, " keys delivered"}, 64'(p), 64'd16);
        if (!stall) checkOutput({tag, " cycles to last key"}, 64'(cycles), 64'd16);
        checkIdle({tag, " after final"});
    endtask

    vec_t        vecs [8];
    logic [47:0] first_rk;
    logic [47:0] last_rk;
    logic [63:0] rkey;

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b1;
        bus0.i_key_valid = 1'b0;
        bus0.i_key       = '0;
        bus0.i_decrypt   = 1'b0;
        bus0.i_abort     = 1'b0;
        bus0.i_rk_ready  = 1'b0;

        vecs[0] = '{KEY_GOOD, 1'b0, 1'b0, K1_GOOD,  K16_GOOD, 1'b1, 1'b0};
        vecs[1] = '{KEY_GOOD, 1'b1, 1'b0, K16_GOOD, K1_GOOD,  1'b1, 1'b0};
        vecs[2] = '{KEY_BAD,  1'b0, 1'b1, 48'h0,    48'h0,    1'b0, 1'b0};
        vecs[3] = '{KEY_GOOD, 1'b0, 1'b0, K1_GOOD,  K16_GOOD, 1'b1, 1'b1};
        vecs[4] = '{KEY_GOOD, 1'b1, 1'b0, K16_GOOD, K1_GOOD,  1'b1, 1'b1};
        for (int i = 5; i < 8; i++) begin
            vecs[i].key        = {$urandom(), $urandom()};
            vecs[i].decrypt    = 1'($urandom_range(0, 1));
            vecs[i].exp_parity = modelParity(vecs[i].key);
            vecs[i].exp_first  = '0;
            vecs[i].exp_last   = '0;
            vecs[i].has_kat    = 1'b0;
            vecs[i].stall      = (i != 6);
        end

        // Reset values
        #3;
        checkOutput("reset key_ready", 64'(bus0.o_key_ready), 64'd1);
        checkOutput("reset rk_valid", 64'(bus0.o_rk_valid), 64'd0);
        checkOutput("reset rk", 64'(bus0.o_rk), 64'd0);
        checkOutput("reset rk_idx", 64'(bus0.o_rk_idx), 64'd0);
        checkOutput("reset last", 64'(bus0.o_last), 64'd0);
        checkOutput("reset busy", 64'(bus0.o_busy), 64'd0);
        checkOutput("reset parity_err", 64'(bus0.o_parity_err), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Table-driven schedules
        for (int v = 0; v < 8; v++) begin
            runSchedule($sformatf("vec%0d", v), vecs[v].key, vecs[v].decrypt, vecs[v].stall,
                        first_rk, last_rk);
            checkOutput($sformatf("vec%0d parity_err", v), 64'(bus0.o_parity_err),
                        64'(vecs[v].exp_parity));
            checkOutput($sformatf("vec%0d parity_err unchecked", v), 64'(bus1.o_parity_err), 64'd0);
            if (vecs[v].has_kat) begin
                checkOutput($sformatf("vec%0d first key", v), 64'(first_rk), 64'(vecs[v].exp_first));
                checkOutput($sformatf("vec%0d last key", v), 64'(last_rk), 64'(vecs[v].exp_last));
            end
            step();
        end

        // Abort at round 5: wins over the simultaneous handshake
        applyStimulus("abort", KEY_GOOD, 1'b0);
        for (int p = 0; p < 4; p++) begin
            checkRound("abort pre", expectedRk(KEY_GOOD, 1'b0, p), p);
            bus0.i_rk_ready = 1'b1;
            step();
        end
        checkRound("abort round5", expectedRk(KEY_GOOD, 1'b0, 4), 4);
        bus0.i_abort = 1'b1;
        step();
        bus0.i_abort    = 1'b0;
        bus0.i_rk_ready = 1'b0;
        checkIdle("abort next cycle");
        checkOutput("abort rk cleared", 64'(bus0.o_rk), 64'd0);
        step();
        checkIdle("abort settled");
        runSchedule("post-abort", KEY_GOOD, 1'b0, 1'b0, first_rk, last_rk);
        checkOutput("post-abort K1", 64'(first_rk), 64'(K1_GOOD));

        // Abort while idle does not block a key offered on the same cycle
        bus0.i_abort = 1'b1;
        rkey = {$urandom(), $urandom()};
        applyStimulus("idle-abort", rkey, 1'b0);
        bus0.i_abort = 1'b0;
        checkRound("idle-abort", expectedRk(rkey, 1'b0, 0), 0);
        bus0.i_abort = 1'b1;
        step();
        bus0.i_abort = 1'b0;
        checkIdle("idle-abort cleanup");

        // Reset at round 9 of a bad-parity schedule
        applyStimulus("reset-run", KEY_BAD, 1'b1);
        for (int p = 0; p < 8; p++) begin
            checkRound("reset-run", expectedRk(KEY_BAD, 1'b1, p), p);
            bus0.i_rk_ready = 1'b1;
            step();
        end
        checkRound("reset-run round9", expectedRk(KEY_BAD, 1'b1, 8), 8);
        checkOutput("reset-run parity_err set", 64'(bus0.o_parity_err), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrun reset key_ready", 64'(bus0.o_key_ready), 64'd1);
        checkOutput("midrun reset rk_valid", 64'(bus0.o_rk_valid), 64'd0);
        checkOutput("midrun reset rk", 64'(bus0.o_rk), 64'd0);
        checkOutput("midrun reset rk_idx", 64'(bus0.o_rk_idx), 64'd0);
        checkOutput("midrun reset last", 64'(bus0.o_last), 64'd0);
        checkOutput("midrun reset busy", 64'(bus0.o_busy), 64'd0);
        checkOutput("midrun reset parity_err", 64'(bus0.o_parity_err), 64'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("after reset rk_valid", 64'(bus0.o_rk_valid), 64'd0);
        end
        bus0.i_rk_ready = 1'b0;
        runSchedule("post-reset", KEY_GOOD, 1'b0, 1'b0, first_rk, last_rk);
        checkOutput("post-reset K1", 64'(first_rk), 64'(K1_GOOD));
        checkOutput("post-reset K16", 64'(last_rk), 64'(K16_GOOD));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
